// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch funct3 codes,
// 2-bit BHT counter states and the resolver FSM states.
package branch_resolver_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    typedef enum logic {
        S_RUN    = 1'b0,
        S_SHADOW = 1'b1
    } rs_state_t;

    function automatic logic [1:0] bht_sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'd1;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_resolver_bht_2bit.sv
// 2-bit saturating branch history table: one combinational read port for IF,
// one saturating-update write port from EX. No read/write bypass.
module bht_2bit
    import branch_resolver_pkg::*;
#(
    parameter int IDX_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IDX_BITS-1:0] i_rd_idx,
    output logic                o_rd_taken,
    input  logic                i_wr_en,
    input  logic [IDX_BITS-1:0] i_wr_idx,
    input  logic                i_wr_taken
);

    localparam int ENTRIES = 2 ** IDX_BITS;

    logic [1:0] r_tbl [ENTRIES];
    logic [1:0] w_rd_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_tbl[i] <= WNT;
            end
        end else if (i_wr_en) begin
            r_tbl[i_wr_idx] <= bht_sat_update(r_tbl[i_wr_idx], i_wr_taken);
        end
    end

    // Same-cycle write to the read index is intentionally not forwarded.
    assign w_rd_cnt   = r_tbl[i_rd_idx];
    assign o_rd_taken = w_rd_cnt[1];

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch/jump resolver: evaluates the branch condition from ALU flags,
// checks the IF prediction, issues a registered redirect/flush and trains the BHT.
module branch_resolver
    import branch_resolver_pkg::*;
#(
    parameter int IDX_BITS = 6,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [2:0]       ex_funct3,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    input  logic             alu_zero,
    input  logic             alu_lt,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             flush,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    rs_state_t        r_state;
    rs_state_t        w_state_next;
    logic             w_taken;
    logic             w_known;
    logic             w_accept;
    logic             w_mispred;
    logic             w_redirect;
    logic             w_bht_wr;
    logic             r_redirect_valid;
    logic [31:0]      r_redirect_pc;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;
    logic             w_unused_if_pc;

    // Jumps win over branches; unknown branch funct3 is neither resolved nor counted.
    always_comb begin
        w_taken = 1'b0;
        w_known = 1'b1;
        if (ex_is_jump) begin
            w_taken = 1'b1;
        end else begin
            case (ex_funct3)
                F3_BEQ:           w_taken = alu_zero;
                F3_BNE:           w_taken = ~alu_zero;
                F3_BLT, F3_BLTU:  w_taken = alu_lt;
                F3_BGE, F3_BGEU:  w_taken = ~alu_lt;
                default:          w_known = 1'b0;
            endcase
        end
    end

    assign w_accept   = ex_valid & (ex_is_jump | (ex_is_branch & w_known)) & (r_state == S_RUN);
    assign w_mispred  = (w_taken != ex_pred_taken) | (w_taken & (ex_pred_target != ex_target));
    assign w_redirect = w_accept & w_mispred;
    assign w_bht_wr   = w_accept & ~ex_is_jump;

    bht_2bit #(
        .IDX_BITS (IDX_BITS)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (if_pc[IDX_BITS+1:2]),
        .o_rd_taken (if_pred_taken),
        .i_wr_en    (w_bht_wr),
        .i_wr_idx   (ex_pc[IDX_BITS+1:2]),
        .i_wr_taken (w_taken)
    );

    assign w_unused_if_pc = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_next;
    end

    // The instruction right behind a mispredict is wrong-path: skip exactly one cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:    if (w_redirect) w_state_next = S_SHADOW;
            S_SHADOW: w_state_next = S_RUN;
            default:  w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
        end else begin
            r_redirect_valid <= w_redirect;
            if (w_redirect) begin
                r_redirect_pc <= w_taken ? ex_target : ex_pc + 32'd4;
            end
        end
    end

    // Statistics saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (w_accept) begin
            if (r_branch_cnt != {CNT_W{1'b1}}) r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_mispred && (r_mispred_cnt != {CNT_W{1'b1}})) r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign flush          = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign branch_cnt     = r_branch_cnt;
    assign mispred_cnt    = r_mispred_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: directed vectors push expected redirects,
// a monitor pops and compares them when the DUT signals a redirect.
module tb_branch_resolver;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ex_valid = 1'b0, ex_is_branch = 1'b0, ex_is_jump = 1'b0;
    logic [2:0]  ex_funct3 = 3'b0;
    logic [31:0] ex_pc = 32'd0, ex_target = 32'd0, ex_pred_target = 32'd0, if_pc = 32'd0;
    logic        ex_pred_taken = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0;

    logic        if_pred_taken, redirect_valid, flush;
    logic [31:0] redirect_pc, branch_cnt, mispred_cnt;
    logic        s_if_pred_taken, s_redirect_valid, s_flush;
    logic [31:0] s_redirect_pc;
    logic [2:0]  s_branch_cnt, s_mispred_cnt;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    branch_resolver #(.IDX_BITS(6), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .alu_zero(alu_zero),
        .alu_lt(alu_lt), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Narrow-counter copy on the same stimulus exercises counter saturation.
    branch_resolver #(.IDX_BITS(6), .CNT_W(3)) dut_sat (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_branch(ex_is_branch),
        .ex_is_jump(ex_is_jump), .ex_funct3(ex_funct3), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .alu_zero(alu_zero),
        .alu_lt(alu_lt), .if_pc(if_pc), .if_pred_taken(s_if_pred_taken),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compare every redirect against the scoreboard, including its cycle.
    always @(posedge clk) begin
        #1;
        if (redirect_valid) begin
            chk("flush_eq_redirect", {31'd0, flush}, 32'd1);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_redirect: got pc 0x%08h at cycle %0d expected none", redirect_pc, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("redirect_pc", redirect_pc, e.pc);
                chk("redirect_cycle", cyc, e.cyc);
            end
        end else if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_redirect: got none at cycle %0d expected pc 0x%08h", cyc, e.pc);
        end
    end

    task automatic issue(input logic isb, input logic isj, input logic [2:0] f3,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptg,
                         input logic z, input logic lt,
                         input logic redir, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        ex_valid = 1'b1; ex_is_branch = isb; ex_is_jump = isj; ex_funct3 = f3;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptg;
        alu_zero = z; alu_lt = lt;
        if (redir) begin
            e.cyc = cyc + 1;
            e.pc  = rpc;
            q.push_back(e);
        end
        @(posedge clk);
        #2;
        ex_valid = 1'b0; ex_is_branch = 1'b0; ex_is_jump = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #2;
    endtask

    task automatic pred(input string nm, input logic [31:0] pc, input logic exp);
        if_pc = pc;
        #1;
        chk(nm, {31'd0, if_pred_taken}, {31'd0, exp});
    endtask

    task automatic cnts(input string nm, input logic [31:0] b, input logic [31:0] m);
        chk({nm, "_branch_cnt"}, branch_cnt, b);
        chk({nm, "_mispred_cnt"}, mispred_cnt, m);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        cnts("rst", 32'd0, 32'd0);
        for (int i = 0; i < 64; i++) pred("rst_bht", 32'(i) << 2, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, predicted not taken
        issue(1, 0, BEQ, 32'h100, 32'h140, 0, 32'h0, 1, 0, 1, 32'h140);
        pred("beq_bht_wt", 32'h100, 1'b1);
        cnts("beq", 32'd1, 32'd1);
        idle();

        // BNE not taken from a fresh entry, then saturate at SNT
        do_reset();
        cnts("rst2", 32'd0, 32'd0);
        issue(1, 0, BNE, 32'h200, 32'h280, 1, 32'h280, 1, 0, 1, 32'h204);
        idle();
        pred("bne_bht_snt", 32'h200, 1'b0);
        issue(1, 0, BNE, 32'h200, 32'h280, 0, 32'h280, 1, 0, 0, 32'h0);
        pred("bne_bht_sat", 32'h200, 1'b0);
        issue(1, 0, BEQ, 32'h200, 32'h240, 1, 32'h240, 1, 0, 0, 32'h0);
        pred("beq_from_snt", 32'h200, 1'b0);
        issue(1, 0, BEQ, 32'h200, 32'h240, 1, 32'h240, 1, 0, 0, 32'h0);
        pred("beq_to_wt", 32'h200, 1'b1);
        cnts("bne", 32'd4, 32'd1);

        // Mispredict, wrong-path BLT in SHADOW, then BLTU accepted
        issue(1, 0, BGE, 32'h10C, 32'h400, 0, 32'h0, 0, 0, 1, 32'h400);
        issue(1, 0, BLT, 32'h110, 32'h500, 0, 32'h0, 0, 1, 0, 32'h0);
        pred("shadow_no_bht", 32'h110, 1'b0);
        chk("shadow_branch_cnt", branch_cnt, 32'd5);
        issue(1, 0, BLTU, 32'h110, 32'h500, 1, 32'h500, 0, 1, 0, 32'h0);
        pred("after_shadow_bht", 32'h110, 1'b1);
        pred("bge_bht", 32'h10C, 1'b1);
        cnts("shadow", 32'd6, 32'd2);

        // JALR with wrong predicted target
        issue(0, 1, 3'b000, 32'h120, 32'h304, 1, 32'h300, 0, 0, 1, 32'h304);
        idle();
        pred("jalr_no_bht", 32'h120, 1'b0);
        cnts("jalr", 32'd7, 32'd3);

        // Reserved funct3: ignored entirely
        issue(1, 0, 3'b010, 32'h124, 32'h600, 1, 32'h600, 1, 1, 0, 32'h0);
        pred("f3_010_no_bht", 32'h124, 1'b0);
        cnts("f3_010", 32'd7, 32'd3);

        // Jump priority over a not-taken BEQ
        issue(1, 1, BEQ, 32'h128, 32'h700, 1, 32'h700, 0, 0, 0, 32'h0);
        pred("jump_prio_no_bht", 32'h128, 1'b0);
        cnts("jump_prio", 32'd8, 32'd3);

        // Fall-through PC wraps past 2^32
        issue(1, 0, BEQ, 32'hFFFFFFFC, 32'h800, 1, 32'h800, 0, 0, 1, 32'h0);
        idle();
        cnts("wrap", 32'd9, 32'd4);
        chk("sat_branch_cnt", {29'd0, s_branch_cnt}, 32'd7);
        chk("sat_mispred_cnt", {29'd0, s_mispred_cnt}, 32'd4);
        issue(1, 0, BEQ, 32'h130, 32'h900, 1, 32'h900, 1, 0, 0, 32'h0);
        chk("sat_branch_hold", {29'd0, s_branch_cnt}, 32'd7);
        chk("main_branch_cnt", branch_cnt, 32'd10);

        // Async reset during a redirect pulse
        issue(1, 0, BNE, 32'h140, 32'hA00, 1, 32'hA00, 1, 0, 1, 32'h144);
        rst = 1'b1;
        #1;
        chk("rst_mid_redirect", {31'd0, redirect_valid}, 32'd0);
        chk("rst_mid_flush", {31'd0, flush}, 32'd0);
        chk("rst_mid_branch_cnt", branch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_empty", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
